// File: rtl/leaf_stream_pkg.sv
// leaf_stream_pkg: shared constants and helpers
// for the per-channel leaf stream buffer.
package leaf_stream_pkg;

  localparam int PAYLOAD_DEF = 32;
  localparam int DEPTH_DEF   = 16;

  // Occupancy must be able to hold DEPTH itself.
  function automatic int occ_width(int depth);
    return $clog2(depth + 1);
  endfunction

  // Low bit of lane idx in a flat bus.
  function automatic int lane_lo(int idx, int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/leaf_chan_fifo.sv
// leaf_chan_fifo: one elastic channel with
// occupancy, almost-full and pop counter.
module leaf_chan_fifo
  import leaf_stream_pkg::*;
#(
  parameter int PAYLOAD_BITS = PAYLOAD_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int AFULL_LEVEL  = 12,
  parameter int CNT_BITS     = 16,
  parameter int OW = occ_width(DEPTH)
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    din_vld,
  output logic                    din_ack,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    dout_vld,
  input  logic                    dout_ack,
  input  logic                    flush,
  output logic [OW-1:0]           occupancy,
  output logic                    afull,
  output logic [CNT_BITS-1:0]     xfer_cnt
);

  localparam int PW = $clog2(DEPTH);

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] count;
  logic [OW-1:0] count_nxt;
  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count == OW'(DEPTH));
  assign empty = (count == '0);

  assign din_ack  = !full && !flush;
  assign dout_vld = !empty;

  // Flush wins, so neither side moves that cycle.
  assign push = din_vld && din_ack;
  assign pop  = dout_vld && dout_ack && !flush;

  // Head is read from registered state only;
  // forced to zero while the channel is empty.
  assign dout      = empty ? '0 : mem[rd_ptr];
  assign occupancy = count;

  // Next occupancy, shared by count and afull.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + OW'(1);
    end else if (pop && !push) begin
      count_nxt = count - OW'(1);
    end
  end

  // Pointers, occupancy, afull and counter.
  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      afull    <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      count <= count_nxt;
      afull <= (count_nxt >= OW'(AFULL_LEVEL));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) begin
          rd_ptr   <= rd_ptr + PW'(1);
          xfer_cnt <= xfer_cnt + CNT_BITS'(1);
        end
      end
    end
  end

  // Storage needs no reset; empty masks it.
  always_ff @(posedge clk_user) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/leaf_stream_buffer.sv
// leaf_stream_buffer: NUM_PORTS independent
// elastic channels; this level only slices buses.
module leaf_stream_buffer
  import leaf_stream_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int PAYLOAD_BITS = PAYLOAD_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int AFULL_LEVEL  = 12,
  parameter int CNT_BITS     = 16
) (
  input  logic clk_user,
  input  logic reset,
  input  logic [NUM_PORTS*PAYLOAD_BITS-1:0] din,
  input  logic [NUM_PORTS-1:0] din_vld,
  output logic [NUM_PORTS-1:0] din_ack,
  output logic [NUM_PORTS*PAYLOAD_BITS-1:0] dout,
  output logic [NUM_PORTS-1:0] dout_vld,
  input  logic [NUM_PORTS-1:0] dout_ack,
  input  logic [NUM_PORTS-1:0] flush,
  output logic [NUM_PORTS*occ_width(DEPTH)-1:0]
    occupancy,
  output logic [NUM_PORTS-1:0] afull,
  output logic [NUM_PORTS*CNT_BITS-1:0] xfer_cnt
);

  localparam int OW = occ_width(DEPTH);

  for (genvar i = 0; i < NUM_PORTS; i++) begin
    : g_chan
    leaf_chan_fifo #(
      .PAYLOAD_BITS (PAYLOAD_BITS),
      .DEPTH        (DEPTH),
      .AFULL_LEVEL  (AFULL_LEVEL),
      .CNT_BITS     (CNT_BITS),
      .OW           (OW)
    ) u_fifo (
      .clk_user  (clk_user),
      .reset     (reset),
      .din       (din[lane_lo(i, PAYLOAD_BITS)
                      +: PAYLOAD_BITS]),
      .din_vld   (din_vld[i]),
      .din_ack   (din_ack[i]),
      .dout      (dout[lane_lo(i, PAYLOAD_BITS)
                       +: PAYLOAD_BITS]),
      .dout_vld  (dout_vld[i]),
      .dout_ack  (dout_ack[i]),
      .flush     (flush[i]),
      .occupancy (occupancy[lane_lo(i, OW)
                            +: OW]),
      .afull     (afull[i]),
      .xfer_cnt  (xfer_cnt[lane_lo(i, CNT_BITS)
                           +: CNT_BITS])
    );
  end

endmodule

// File: tb/tb_leaf_stream_buffer.sv
// tb_leaf_stream_buffer: directed and random
// stimulus against a queue-based reference.
module tb_leaf_stream_buffer;

  localparam int NP  = 2;
  localparam int PB  = 32;
  localparam int DEP = 16;
  localparam int AFL = 12;
  localparam int CB  = 16;
  localparam int OW  = $clog2(DEP + 1);

  logic clk_user = 1'b0;
  logic reset;
  logic [NP*PB-1:0] din;
  logic [NP-1:0] din_vld;
  logic [NP-1:0] din_ack;
  logic [NP*PB-1:0] dout;
  logic [NP-1:0] dout_vld;
  logic [NP-1:0] dout_ack;
  logic [NP-1:0] flush;
  logic [NP*OW-1:0] occupancy;
  logic [NP-1:0] afull;
  logic [NP*CB-1:0] xfer_cnt;

  int errors = 0;
  int checks = 0;

  logic [PB-1:0] q [NP][$];
  int unsigned mcnt [NP];

  leaf_stream_buffer #(
    .NUM_PORTS    (NP),
    .PAYLOAD_BITS (PB),
    .DEPTH        (DEP),
    .AFULL_LEVEL  (AFL),
    .CNT_BITS     (CB)
  ) dut (
    .clk_user  (clk_user),
    .reset     (reset),
    .din       (din),
    .din_vld   (din_vld),
    .din_ack   (din_ack),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_ack  (dout_ack),
    .flush     (flush),
    .occupancy (occupancy),
    .afull     (afull),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk_user = ~clk_user;

  task automatic chk(string tag, int ch,
                     logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s ch%0d got=%0h exp=%0h",
               tag, ch, got, exp);
      $error("check %s ch%0d", tag, ch);
    end
  endtask

  function automatic logic [PB-1:0] g_dout(int c);
    return dout[c*PB +: PB];
  endfunction

  function automatic logic [OW-1:0] g_occ(int c);
    return occupancy[c*OW +: OW];
  endfunction

  function automatic logic [CB-1:0] g_cnt(int c);
    return xfer_cnt[c*CB +: CB];
  endfunction

  task automatic check_all();
    for (int c = 0; c < NP; c++) begin
      int sz = q[c].size();
      chk("din_ack", c, 64'(din_ack[c]),
          64'((sz < DEP) && !flush[c]));
      chk("dout_vld", c, 64'(dout_vld[c]),
          64'(sz > 0));
      chk("dout", c, 64'(g_dout(c)),
          (sz > 0) ? 64'(q[c][0]) : 64'd0);
      chk("occ", c, 64'(g_occ(c)), 64'(sz));
      chk("afull", c, 64'(afull[c]),
          64'(sz >= AFL));
      chk("xfer", c, 64'(g_cnt(c)),
          64'(mcnt[c] % (1 << CB)));
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < NP; c++) begin
      int  sz  = q[c].size();
      bit  acc = (sz < DEP) && !flush[c];
      bit  psh = din_vld[c] && acc;
      bit  pp  = (sz > 0) && dout_ack[c]
                 && !flush[c];
      if (flush[c]) begin
        q[c].delete();
      end else begin
        if (pp) begin
          void'(q[c].pop_front());
          mcnt[c]++;
        end
        if (psh) q[c].push_back(din[c*PB +: PB]);
      end
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NP; c++) begin
      q[c].delete();
      mcnt[c] = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk_user);
    check_all();
    model_update();
    @(posedge clk_user);
    #1;
  endtask

  task automatic idle();
    din_vld  = '0;
    dout_ack = '0;
    flush    = '0;
  endtask

  int unsigned cnt_save;

  initial begin
    reset = 1'b1;
    din = '0;
    idle();
    model_clear();
    @(negedge clk_user);
    check_all();
    reset = 1'b0;
    @(posedge clk_user);
    #1;

    // single word through ch0
    din[0 +: PB] = 32'hA5A5_0001;
    din_vld[0]   = 1'b1;
    dout_ack[0]  = 1'b1;
    tick();
    din_vld[0] = 1'b0;
    chk("first_vld", 0, 64'(dout_vld[0]), 64'd1);
    chk("first_dat", 0, 64'(g_dout(0)),
        64'hA5A5_0001);
    tick();
    chk("first_cnt", 0, 64'(g_cnt(0)), 64'd1);
    idle();
    tick();

    // fill ch1, no drain, one extra attempt
    for (int i = 0; i < DEP + 1; i++) begin
      din[PB +: PB] = 32'h1100_0000 + 32'(i);
      din_vld[1] = 1'b1;
      tick();
      if (i == AFL - 1)
        chk("afull_at", 1, 64'(afull[1]), 64'd1);
    end
    din_vld[1] = 1'b0;
    chk("full_ack", 1, 64'(din_ack[1]), 64'd0);
    chk("full_occ", 1, 64'(g_occ(1)), 64'(DEP));
    chk("ch0_idle", 0, 64'(g_occ(0)), 64'd0);

    // one pop from full ch1
    dout_ack[1] = 1'b1;
    tick();
    dout_ack[1] = 1'b0;
    chk("pop_ack", 1, 64'(din_ack[1]), 64'd1);
    chk("pop_occ", 1, 64'(g_occ(1)), 64'(DEP-1));
    tick();

    // streaming 0..39 on ch0
    for (int i = 0; i < 40; i++) begin
      din[0 +: PB] = 32'(i);
      din_vld[0]  = 1'b1;
      dout_ack[0] = 1'b1;
      tick();
    end
    chk("stream_occ", 0, 64'(g_occ(0)), 64'd1);
    din_vld[0] = 1'b0;
    tick();
    tick();

    // flush ch0 holding 5 words
    idle();
    for (int i = 0; i < 5; i++) begin
      din[0 +: PB] = 32'h0F00_0000 + 32'(i);
      din_vld[0] = 1'b1;
      tick();
    end
    cnt_save = mcnt[0];
    din[0 +: PB] = 32'hDEAD_BEEF;
    flush[0] = 1'b1;
    tick();
    idle();
    chk("flush_occ", 0, 64'(g_occ(0)), 64'd0);
    chk("flush_vld", 0, 64'(dout_vld[0]), 64'd0);
    chk("flush_cnt", 0, 64'(g_cnt(0)),
        64'(cnt_save));
    tick();

    // random traffic on both channels
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NP; c++) begin
        din[c*PB +: PB] = $urandom;
        din_vld[c]  = ($urandom_range(3) != 0);
        dout_ack[c] = ($urandom_range(2) != 0);
        flush[c]    = ($urandom_range(40) == 0);
      end
      tick();
    end
    idle();
    tick();

    // drain ch1 then load 7 words
    dout_ack[1] = 1'b1;
    for (int i = 0; i < DEP + 1; i++) tick();
    idle();
    for (int i = 0; i < 7; i++) begin
      din[PB +: PB] = $urandom;
      din_vld[1] = 1'b1;
      tick();
    end
    idle();
    tick();
    chk("pre_rst", 1, 64'(g_occ(1)), 64'd7);

    // async reset between edges
    #1;
    reset = 1'b1;
    #1;
    model_clear();
    check_all();
    @(negedge clk_user);
    reset = 1'b0;
    @(posedge clk_user);
    #1;
    for (int i = 0; i < 3; i++) tick();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/leaf_stream_buffer.md
Name: leaf_stream_buffer

Overview:
Parametrised per-channel elastic buffer between leaf_interface user-side streams and an HLS kernel's ap_vld/ap_ack ports, all in the clk_user domain. Each of NUM_PORTS channels is an independent FIFO with a vld/ack handshake on both sides, per-channel flush, occupancy, almost-full flag and a transfer counter. One instance is used on the input side of a leaf and one on the output side, so wider kernels no longer stall the BFT on single-beat back-pressure.

Parameters:
NUM_PORTS, 2, number of independent stream channels (1..16)
PAYLOAD_BITS, 32, data width per channel
DEPTH, 16, entries per channel FIFO; power of two, >=2
AFULL_LEVEL, 12, occupancy at or above which afull is asserted (1..DEPTH)
CNT_BITS, 16, width of per-channel transfer counter

Ports:
clk_user  in  1  user clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
din  in  NUM_PORTS*PAYLOAD_BITS  upstream data; channel i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
din_vld  in  NUM_PORTS  upstream valid per channel
din_ack  out  NUM_PORTS  upstream accept per channel
dout  out  NUM_PORTS*PAYLOAD_BITS  downstream data (FIFO head)
dout_vld  out  NUM_PORTS  downstream valid per channel
dout_ack  in  NUM_PORTS  downstream accept per channel
flush  in  NUM_PORTS  synchronous per-channel clear
occupancy  out  NUM_PORTS*$clog2(DEPTH+1)  entries held per channel
afull  out  NUM_PORTS  occupancy >= AFULL_LEVEL
xfer_cnt  out  NUM_PORTS*CNT_BITS  count of completed downstream transfers per channel

Behaviour:
- Reset (async assert, sync release on clk_user): all FIFOs empty; din_ack=all 1, dout_vld=0, dout=0, occupancy=0, afull=0, xfer_cnt=0.
- Push on channel i when din_vld[i] & din_ack[i]; pop when dout_vld[i] & dout_ack[i].
- din_ack[i] = !full[i] & !flush[i]; depends only on registered state and flush, never on din_vld.
- dout_vld[i] = !empty[i]; dout[i] = head entry, registered/stable while dout_vld & !dout_ack (no change under back-pressure).
- Latency: word pushed into empty channel appears on dout_vld the next cycle; no combinational din->dout path.
- Simultaneous push and pop on non-empty, non-full channel: occupancy unchanged, order preserved.
- Full channel: din_ack=0; a pop that cycle frees a slot, din_ack=1 next cycle (no same-cycle pass-through).
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH; full/empty from separate occupancy counter of width $clog2(DEPTH+1).
- flush[i]: highest priority; that cycle ignores push/pop on i, next cycle channel empty, occupancy 0, dout_vld 0. xfer_cnt[i] not cleared by flush.
- xfer_cnt[i] increments by 1 on each pop, wraps at 2^CNT_BITS.
- afull registered from next-state occupancy, so it tracks occupancy with no extra lag.
- Channels fully independent; no shared arbitration.
- Reset mid-transfer: in-flight data discarded, outputs return to reset values asynchronously.

Decomposition:
- Shared package leaf_stream_pkg: occupancy width function, default PAYLOAD_BITS/DEPTH constants, lane-slice helper.
- Sub-module leaf_chan_fifo (one channel: storage, pointers, occupancy, afull, counter), instantiated NUM_PORTS times in a generate loop; top handles only bus slicing.

Test Plan:
- Reset then push 0xA5A5_0001 on ch0, dout_ack=1 -> dout_vld[0] rises one cycle after the push, dout=0xA5A5_0001, xfer_cnt[0]=1.
- Fill ch1 with 16 words, dout_ack=0 -> din_ack[1]=0 after 16th push, occupancy[1]=16, afull[1] from the 12th word; ch0 unaffected.
- Full ch1, dout_ack[1]=1 for one cycle -> head popped, din_ack[1]=1 next cycle, occupancy 15.
- Continuous push/pop on ch0 for 40 words 0..39 -> output sequence 0..39 in order, occupancy steady, pointers wrap twice.
- Ch0 holding 5 words, flush[0] with din_vld[0]=1 same cycle -> word not accepted, next cycle occupancy 0, dout_vld 0, xfer_cnt unchanged.
- Assert reset with 7 words in ch1 -> outputs go to reset values immediately, before the next clock edge.
